// File: rtl/vga_ctrl.sv
// VGA 640x480@60 timing generator and pixel sink. Free-running h/v counters
// produce a coordinate request one cycle ahead of display enable; the returned
// RGB332 pixel is registered to the DAC together with hsync/vsync/frame_start.
// Ports: vga_clk/sys_rst_n (clock, async active-low reset); pix_data (pixel
// from upstream, one cycle after its request); pix_x/pix_y/pix_req (coordinate
// request, 0x3FF when idle); hsync/vsync/rgb/frame_start (registered outputs).
// No handshake: upstream must return a pixel every cycle.
module vga_ctrl #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_VALID = 640,
  parameter int H_FRONT = 16,
  parameter int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_VALID = 480,
  parameter int V_FRONT = 10,
  parameter int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] pix_data,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_req,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] rgb,
  output logic       frame_start
);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  // Request window opens one clock before the first visible pixel so the
  // upstream register has a cycle to return data.
  localparam logic [9:0] H_REQ_S  = 10'(H_SYNC + H_BACK - 1);
  localparam logic [9:0] H_REQ_E  = 10'(H_SYNC + H_BACK + H_VALID - 1);
  localparam logic [9:0] V_ACT_S  = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT_E  = 10'(V_SYNC + V_BACK + V_VALID);
  localparam logic [9:0] H_SYNC_E = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_E = 10'(V_SYNC);

  logic [9:0] cnt_h;
  logic [9:0] cnt_v;
  logic       de;
  logic       line_end;

  assign line_end = (cnt_h == H_LAST);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h <= '0;
    end else if (line_end) begin
      cnt_h <= '0;
    end else begin
      cnt_h <= cnt_h + 10'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_v <= '0;
    end else if (line_end) begin
      if (cnt_v == V_LAST) begin
        cnt_v <= '0;
      end else begin
        cnt_v <= cnt_v + 10'd1;
      end
    end
  end

  always_comb begin
    pix_req = (cnt_h >= H_REQ_S) && (cnt_h < H_REQ_E) &&
              (cnt_v >= V_ACT_S) && (cnt_v < V_ACT_E);
    pix_x   = 10'h3FF;
    pix_y   = 10'h3FF;
    if (pix_req) begin
      pix_x = cnt_h - H_REQ_S;
      pix_y = cnt_v - V_ACT_S;
    end
  end

  // All outputs share one register delay after the counters, so sync edges
  // stay aligned with the pixel that arrives one cycle after its request.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      de          <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      rgb         <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      de          <= pix_req;
      hsync       <= (cnt_h < H_SYNC_E);
      vsync       <= (cnt_v < V_SYNC_E);
      rgb         <= de ? pix_data : 8'h00;
      frame_start <= (cnt_h == 10'd0) && (cnt_v == 10'd0);
    end
  end

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: full horizontal timing, shortened vertical timing so
// two complete frames fit in a short run. Outputs are predicted from the
// number of clock edges since reset release.
module tb_vga_ctrl;

  localparam int HS = 96, HB = 48, HV = 640, HF = 16, HT = 800;
  localparam int VS = 2, VB = 3, VV = 4, VF = 2, VT = 11;
  localparam int FRAME = HT * VT;

  logic       vga_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] pix_data = 8'h00;
  logic [9:0] pix_x, pix_y;
  logic       pix_req, hsync, vsync, frame_start;
  logic [7:0] rgb;

  int  edges = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  const_mode = 1'b0;
  bit  run_active = 1'b0;
  bit  count_en = 1'b0;
  int  cnt_hs = 0, cnt_vs = 0, cnt_fs = 0, cnt_req = 0;

  vga_ctrl #(
    .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF)
  ) dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_start(frame_start)
  );

  always #20 vga_clk = ~vga_clk;

  always @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) edges <= 0;
    else            edges <= edges + 1;
  end

  // Upstream picture generator: a register returning pix_x[7:0] (or 0xFF).
  initial begin
    logic [7:0] nxt;
    forever begin
      @(negedge vga_clk);
      nxt = const_mode ? 8'hFF : pix_x[7:0];
      @(posedge vga_clk);
      #1;
      pix_data = nxt;
    end
  end

  // ---------------- model: everything is a function of edge count k ------
  function automatic int h_at(input int k); return k % HT; endfunction
  function automatic int v_at(input int k); return (k / HT) % VT; endfunction

  function automatic bit req_at(input int k);
    int h, v;
    h = h_at(k);
    v = v_at(k);
    return (h >= HS + HB - 1) && (h < HS + HB - 1 + HV) &&
           (v >= VS + VB) && (v < VS + VB + VV);
  endfunction

  function automatic logic [9:0] x_at(input int k);
    return req_at(k) ? 10'(h_at(k) - (HS + HB - 1)) : 10'h3FF;
  endfunction

  function automatic logic [9:0] y_at(input int k);
    return req_at(k) ? 10'(v_at(k) - (VS + VB)) : 10'h3FF;
  endfunction

  // {pix_req, pix_x, pix_y, hsync, vsync, rgb, frame_start}
  function automatic logic [31:0] exp_vec(input int k, input bit cm);
    logic       hs, vs, fs;
    logic [7:0] px;
    logic [9:0] xo;
    hs = (k >= 1) && (h_at(k - 1) < HS);
    vs = (k >= 1) && (v_at(k - 1) < VS);
    fs = (k >= 1) && (h_at(k - 1) == 0) && (v_at(k - 1) == 0);
    px = 8'h00;
    if (k >= 2 && req_at(k - 2)) begin
      xo = x_at(k - 2);
      px = cm ? 8'hFF : xo[7:0];
    end
    return {req_at(k), x_at(k), y_at(k), hs, vs, px, fs};
  endfunction

  localparam logic [31:0] RST_VEC = {1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 8'h00, 1'b0};

  function automatic logic [31:0] act_vec();
    return {pix_req, pix_x, pix_y, hsync, vsync, rgb, frame_start};
  endfunction

  // ---------------- per-cycle comparison against the model ---------------
  always @(negedge vga_clk) begin
    if (run_active) begin
      logic [31:0] e, a;
      e = sys_rst_n ? exp_vec(edges, const_mode) : RST_VEC;
      a = act_vec();
      n_cmp = n_cmp + 1;
      if (a !== e) begin
        n_bad = n_bad + 1;
        $display("FAIL cycle k=%0d rst_n=%b: got %h expected %h", edges, sys_rst_n, a, e);
      end
    end
  end

  // ---------------- directed helpers --------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s at k=%0d: got %0h expected %0h", name, edges, act, exp);
    end
  endtask

  // Advance to the negedge where edges==k, counting output activity.
  task automatic run_to(input int k);
    int budget;
    budget = k - edges + 5;
    while (edges < k) begin
      @(negedge vga_clk);
      if (count_en && edges >= 1 && edges <= 2 * FRAME) begin
        cnt_hs  += int'(hsync);
        cnt_vs  += int'(vsync);
        cnt_fs  += int'(frame_start);
        cnt_req += int'(pix_req);
      end
      budget--;
      if (budget < 0) begin
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $display("FAIL run_to timeout waiting k=%0d got k=%0d", k, edges);
        return;
      end
    end
  endtask

  task automatic hold_reset_check(input string name);
    for (int i = 0; i < 10; i++) begin
      @(negedge vga_clk);
      if (i == 5) chk(name, act_vec(), RST_VEC);
    end
  endtask

  initial begin
    run_active = 1'b1;
    sys_rst_n  = 1'b0;
    hold_reset_check("reset_state");
    @(posedge vga_clk); #2;
    sys_rst_n = 1'b1;
    count_en  = 1'b1;

    run_to(1);   chk("fs_first",   32'(frame_start), 32'd1);
                 chk("hs_first",   32'(hsync),       32'd1);
                 chk("vs_first",   32'(vsync),       32'd1);
    run_to(2);   chk("fs_once",    32'(frame_start), 32'd0);
    run_to(96);  chk("hs_last",    32'(hsync),       32'd1);
    run_to(97);  chk("hs_off",     32'(hsync),       32'd0);
    run_to(1600); chk("vs_last",   32'(vsync),       32'd1);
    run_to(1601); chk("vs_off",    32'(vsync),       32'd0);
    run_to(3600); chk("line_before_active", 32'(pix_req), 32'd0);
    run_to(4142); chk("req_pre",   {pix_req, pix_x}, {1'b0, 10'h3FF});
    run_to(4143); chk("req_rise",  {pix_req, pix_x, pix_y}, {1'b1, 10'd0, 10'd0});
    run_to(4145); chk("rgb_px0",   32'(rgb), 32'h00);
    run_to(4146); chk("rgb_px1",   32'(rgb), 32'h01);
    run_to(4272); chk("rgb_px127", 32'(rgb), 32'h7F);
    run_to(4782); chk("req_last",  {pix_req, pix_x}, {1'b1, 10'd639});
    run_to(4783); chk("req_fall",  {pix_req, pix_x}, {1'b0, 10'h3FF});
    run_to(4784); chk("rgb_px639", 32'(rgb), 32'h7F);
    run_to(6900); chk("last_line", {pix_req, pix_x, pix_y}, {1'b1, 10'd357, 10'd3});
    run_to(7600); chk("line_after_active", 32'(pix_req), 32'd0);
    run_to(8800); chk("wrap_fs_pre",  32'(frame_start), 32'd0);
    run_to(8801); chk("wrap_fs",      32'(frame_start), 32'd1);
    run_to(8802); chk("wrap_fs_post", 32'(frame_start), 32'd0);
    run_to(2 * FRAME);
    count_en = 1'b0;
    chk("hsync_total", 32'(cnt_hs),  32'(2 * VT * HS));
    chk("vsync_total", 32'(cnt_vs),  32'(2 * VS * HT));
    chk("fs_total",    32'(cnt_fs),  32'd2);
    chk("req_total",   32'(cnt_req), 32'(2 * VV * HV));

    // Mid-line reset at cnt_h=400, then restart with a constant-0xFF source.
    run_to(2 * FRAME + 399);
    @(posedge vga_clk); #2;
    sys_rst_n  = 1'b0;
    const_mode = 1'b1;
    #1;
    chk("midline_reset_now", act_vec(), RST_VEC);
    hold_reset_check("midline_reset_hold");
    @(posedge vga_clk); #2;
    sys_rst_n = 1'b1;
    @(negedge vga_clk);
    chk("restart_h0", {32'(edges), 32'(hsync)}, {32'd0, 32'd0});
    run_to(1);    chk("restart_fs",   32'(frame_start), 32'd1);
    run_to(4144); chk("blank_before", 32'(rgb), 32'h00);
    run_to(4145); chk("const_active", 32'(rgb), 32'hFF);
    run_to(4785); chk("blank_after",  32'(rgb), 32'h00);
    run_to(FRAME + 5);

    run_active = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_ctrl.md
Name: vga_ctrl

Overview:
- VGA timing generator and pixel sink for the 640x480@60 Hz display path.
- Runs from the 25 MHz pixel clock vga_clk.
- Issues pixel coordinates (pix_x, pix_y) to the upstream picture generator one cycle ahead of display, then accepts the returned 8-bit RGB332 pix_data.
- Drives hsync, vsync and rgb to the DAC/connector, with blanking applied.

Parameters:
- H_SYNC, 96, horizontal sync pulse width in clocks
- H_BACK, 48, horizontal back porch in clocks
- H_VALID, 640, active pixels per line
- H_FRONT, 16, horizontal front porch in clocks
- H_TOTAL, 800, clocks per line (sum of the four above)
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch in lines
- V_VALID, 480, active lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_TOTAL, 525, lines per frame

Ports:
- vga_clk  in  1  pixel clock, 25 MHz
- sys_rst_n  in  1  reset
- pix_data  in  8  RGB332 pixel returned by the upstream block, registered there, valid one cycle after the matching pix_x/pix_y
- pix_x  out  10  requested column 0..639; 10'h3FF when pix_req=0
- pix_y  out  10  requested row 0..479; 10'h3FF when pix_req=0
- pix_req  out  1  coordinate request strobe, one cycle ahead of display enable
- hsync  out  1  horizontal sync, high during sync pulse
- vsync  out  1  vertical sync, high during sync pulse
- rgb  out  8  RGB332 to DAC; 0 during blanking
- frame_start  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Reset is sys_rst_n: asynchronous, active-low. All logic is clocked on vga_clk (rising edge).
- Reset state:
  - cnt_h=0, cnt_v=0.
  - hsync=0, vsync=0, rgb=8'h00, frame_start=0.
  - pix_req=0, pix_x=pix_y=10'h3FF.
- cnt_h (10 bit): counts 0..H_TOTAL-1 and wraps to 0.
- cnt_v (10 bit): increments when cnt_h==H_TOTAL-1; wraps to 0 when cnt_v==V_TOTAL-1 and cnt_h==H_TOTAL-1.
- pix_req is combinational from the counters. It is 1 when both hold:
  - cnt_h in [H_SYNC+H_BACK-1, H_SYNC+H_BACK+H_VALID-1), i.e. 143..782
  - cnt_v in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID), i.e. 35..514
- Coordinates while pix_req=1:
  - pix_x = cnt_h - (H_SYNC+H_BACK-1)
  - pix_y = cnt_v - (V_SYNC+V_BACK)
  - Both are 10'h3FF otherwise (combinational).
- de (internal) is pix_req delayed one cycle, registered. It covers cnt_h 144..783 on active lines.
- Output stage, registered on vga_clk:
  - hsync <= (cnt_h < H_SYNC)
  - vsync <= (cnt_v < V_SYNC)
  - rgb <= de ? pix_data : 8'h00
  - frame_start <= (cnt_h==0 && cnt_v==0)
- Latency and alignment:
  - pix_x request at cycle t -> pix_data at t+1 -> rgb at t+2.
  - hsync, vsync and frame_start carry the same 1-cycle register delay relative to the counters, so sync-to-pixel alignment is preserved.
- Blanking: pix_data is ignored whenever de=0; rgb is forced to 0 regardless of input.
- Per-line totals: exactly 640 request cycles per active line and 480 active lines per frame. No request cycles on blank lines.
- Reset mid-frame: counters and all outputs return to reset values immediately. After release, timing restarts at cnt_h=0, cnt_v=0, and frame_start pulses one cycle after the first clock edge.
- There is no input handshake or backpressure. Upstream must return data every cycle.

Test Plan:
- Reset: hold sys_rst_n low 10 cycles, including a second assertion mid-line at cnt_h=400 -> hsync=vsync=0, rgb=0, pix_req=0, pix_x=pix_y=0x3FF during reset; cnt_h restarts at 0 after release.
- Horizontal timing: run 3 lines -> hsync high exactly 96 consecutive cycles per 800-cycle period.
- Vertical timing: run 2 frames -> vsync high 1600 cycles per 420000-cycle frame; frame_start pulses exactly once per 420000 cycles.
- Request window:
  - cnt_v=35: pix_req rises at cnt_h=143 with pix_x=0, pix_y=0, and falls after cnt_h=782 with pix_x=639.
  - cnt_v=514: pix_y=479.
  - cnt_v=515 and cnt_v=34: pix_req never asserts.
- Data path: upstream model registers pix_data=pix_x[7:0] one cycle later -> rgb runs 0x00,0x01,...,0x7F across 640 consecutive cycles per line; blanking check with upstream driving 0xFF constantly -> rgb=0 outside the window.
- Wrap: at cnt_h=799, cnt_v=524 -> next cycle cnt_h=0, cnt_v=0; frame_start=1 one cycle later for exactly one cycle.
